// File: rtl/data_mem_io_pkg.sv
// Shared definitions for the data-side memory stage:
// I/O register offsets, STATUS bit layout and decode regions.
package data_mem_io_pkg;

  localparam logic [31:0] IO_TXDATA = 32'd0;
  localparam logic [31:0] IO_STATUS = 32'd1;
  localparam logic [31:0] IO_CYCLES = 32'd2;

  localparam int OVF_BIT   = 31;
  localparam int FULL_BIT  = 11;
  localparam int EMPTY_BIT = 10;
  localparam int CNT_LSB   = 0;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_TX,
    REG_STAT,
    REG_CYC
  } region_t;

  function automatic logic [31:0] status_word(
    input logic             ovf,
    input logic             full,
    input logic             empty,
    input logic [CNT_W-1:0] cnt
  );
    logic [31:0] s;
    s = '0;
    s[OVF_BIT]   = ovf;
    s[FULL_BIT]  = full;
    s[EMPTY_BIT] = empty;
    s[CNT_LSB +: CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/data_mem_io_sync_fifo.sv
// Synchronous FIFO with push/pop gating; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             drop,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = mem[rptr];

  // Pointer, count and storage update; reset clears storage too
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/data_mem_io.sv
// Data memory stage: word RAM plus memory-mapped output FIFO,
// FIFO status and free-running cycle counter.
module data_mem_io
  import data_mem_io_pkg::*;
#(
  parameter int          RAM_WORDS  = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] cycles;
  logic        ovf;
  region_t     region;
  logic        f_full;
  logic        f_empty;
  logic        f_drop;
  logic [CW-1:0] f_count;
  logic [31:0] status;

  // Address decode into a single region
  always_comb begin
    region = REG_NONE;
    if (addr < 32'(RAM_WORDS))             region = REG_RAM;
    else if (addr == IO_BASE + IO_TXDATA)  region = REG_TX;
    else if (addr == IO_BASE + IO_STATUS)  region = REG_STAT;
    else if (addr == IO_BASE + IO_CYCLES)  region = REG_CYC;
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (we && region == REG_TX),
    .pop   (out_ready),
    .wdata (wdata),
    .rdata (out_data),
    .full  (f_full),
    .empty (f_empty),
    .drop  (f_drop),
    .count (f_count)
  );

  assign out_valid = !f_empty;
  assign status = status_word(ovf, f_full, f_empty,
                              CNT_W'(f_count));

  // Combinational load path
  always_comb begin
    rdata = '0;
    unique case (region)
      REG_RAM:  rdata = ram[addr[AW-1:0]];
      REG_STAT: rdata = status;
      REG_CYC:  rdata = cycles;
      default:  rdata = '0;
    endcase
  end

  // RAM store; reset clears every word
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
    end else if (we && region == REG_RAM) begin
      ram[addr[AW-1:0]] <= wdata;
    end
  end

  // Sticky overflow: set on dropped push, cleared by STATUS write
  always_ff @(posedge clk) begin
    if (reset)                          ovf <= 1'b0;
    else if (we && region == REG_STAT)  ovf <= 1'b0;
    else if (f_drop)                    ovf <= 1'b1;
  end

  // Free-running cycle counter
  always_ff @(posedge clk) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 32'd1;
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Directed and randomized self-checking bench for data_mem_io.
// Inputs change 1ns after the rising edge; outputs sampled 1ns later.
module tb_data_mem_io;

  localparam logic [31:0] IOB  = 32'hFFFF_FF00;
  localparam logic [31:0] TX   = IOB + 32'd0;
  localparam logic [31:0] STAT = IOB + 32'd1;
  localparam logic [31:0] CYC  = IOB + 32'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  data_mem_io #(
    .RAM_WORDS  (32),
    .FIFO_DEPTH (8),
    .IO_BASE    (IOB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input logic o,
                                       input int n);
    logic [31:0] s;
    s = '0;
    s[31] = o;
    s[11] = (n == 8);
    s[10] = (n == 0);
    s[4:0] = 5'(n);
    return s;
  endfunction

  logic [31:0] mram [32];
  logic [31:0] q [$];
  logic        movf;

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0;
    wdata = '0; out_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_odata", out_data, 32'd0);
    chk("rst_ram0", rdata, 32'd0);

    // counter: reset edge left it at 0
    reset = 1'b0;
    addr = CYC;
    #1;
    chk("cyc0", rdata, 32'd0);
    repeat (10) tick();
    chk("cyc10", rdata, 32'd10);
    dut.cycles = 32'hFFFF_FFFF;
    #1;
    chk("cyc_max", rdata, 32'hFFFF_FFFF);
    tick();
    chk("cyc_wrap", rdata, 32'd0);

    // RAM store/load
    we = 1'b1; addr = 32'd0; wdata = 32'd13;
    tick();
    addr = 32'd31; wdata = 32'd17;
    tick();
    addr = 32'd40; wdata = 32'hBAD;
    tick();
    we = 1'b0; addr = 32'd0;
    #1;
    chk("ram0", rdata, 32'd13);
    addr = 32'd31;
    #1;
    chk("ram31", rdata, 32'd17);
    addr = 32'd32;
    #1;
    chk("ram32", rdata, 32'd0);
    addr = 32'd40;
    #1;
    chk("unmapped", rdata, 32'd0);

    // TXDATA pushes with consumer stalled
    we = 1'b1; addr = TX;
    for (int i = 5; i <= 7; i++) begin
      wdata = 32'(i);
      tick();
    end
    we = 1'b0;
    #1;
    chk("tx_read0", rdata, 32'd0);
    addr = STAT;
    #1;
    chk("stat3", rdata, 32'h0000_0003);
    chk("head5", out_data, 32'd5);
    out_ready = 1'b1;
    #1;
    chk("pop5", out_data, 32'd5);
    tick();
    chk("pop6", out_data, 32'd6);
    tick();
    chk("pop7", out_data, 32'd7);
    tick();
    chk("drained", 32'(out_valid), 32'd0);
    chk("stat_empty", rdata, 32'h0000_0400);
    out_ready = 1'b0;

    // overflow
    we = 1'b1; addr = TX;
    for (int i = 0; i < 8; i++) begin
      wdata = 32'(100 + i);
      tick();
    end
    wdata = 32'hDEAD;
    tick();
    we = 1'b0; addr = STAT;
    #1;
    chk("stat_ovf", rdata, 32'h8000_0808);
    chk("head100", out_data, 32'd100);
    we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    chk("ovf_clr", rdata, 32'h0000_0808);
    we = 1'b1; addr = TX; wdata = 32'd200;
    out_ready = 1'b1;
    tick();
    we = 1'b0; out_ready = 1'b0; addr = STAT;
    #1;
    chk("full_pp", rdata, 32'h0000_0808);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      #1;
      chk("order", out_data, 32'(100 + i));
      tick();
    end
    chk("order_last", out_data, 32'd200);
    tick();
    chk("order_end", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // reset mid-operation
    we = 1'b1; addr = TX;
    for (int i = 1; i <= 3; i++) begin
      wdata = 32'(i);
      tick();
    end
    reset = 1'b1; wdata = 32'd9;
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    addr = STAT;
    #1;
    chk("mr_stat", rdata, 32'h0000_0400);
    addr = 32'd0;
    #1;
    chk("mr_ram0", rdata, 32'd0);
    addr = CYC;
    #1;
    chk("mr_cyc", rdata, 32'd0);

    // randomized traffic against a reference model
    for (int i = 0; i < 32; i++) mram[i] = '0;
    q.delete();
    movf = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      int op;
      int a;
      logic rdy;
      logic pop;
      logic [31:0] exp;
      op  = int'($urandom_range(0, 9));
      a   = int'($urandom_range(0, 31));
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      wdata = $urandom;
      we = 1'b0;
      exp = '0;
      if (op <= 2) begin
        addr = 32'(a); we = 1'b1; exp = mram[a];
      end else if (op <= 4) begin
        addr = 32'(a); exp = mram[a];
      end else if (op <= 7) begin
        addr = TX; we = 1'b1;
      end else begin
        addr = STAT; we = (op == 9);
        exp = stat(movf, q.size());
      end
      #1;
      chk("rnd_rdata", rdata, exp);
      chk("rnd_valid", 32'(out_valid),
          32'(q.size() != 0));
      if (q.size() != 0)
        chk("rnd_odata", out_data, q[0]);
      @(posedge clk);
      pop = rdy && (q.size() != 0);
      if (op <= 2) mram[a] = wdata;
      if (op == 9) movf = 1'b0;
      if (pop) void'(q.pop_front());
      if (op >= 5 && op <= 7) begin
        if (q.size() < 8 || pop) q.push_back(wdata);
        else movf = 1'b1;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory stage sitting directly downstream of the processor's memory port. Provides a word-addressed RAM with combinational read and synchronous write, plus a memory-mapped output channel: stores to a fixed I/O address are pushed into a small FIFO drained by an external consumer over a valid/ready handshake. Also exposes FIFO status and a free-running cycle counter as read-only I/O registers, so programs can emit results and measure run time without bench-side memory peeking.

## Interface

Parameters:
- RAM_WORDS, 32, number of 32-bit RAM words (power of two, 2..256)
- FIFO_DEPTH, 8, output FIFO entries (power of two, 2..16)
- IO_BASE, 32'hFFFF_FF00, base of I/O window

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- addr  in  32  word address from processor
- wdata  in  32  store data from processor
- we  in  1  store enable
- rdata  out  32  load data to processor (combinational)
- out_data  out  32  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle

## Operation

- Address decode: RAM if addr < RAM_WORDS; TXDATA at IO_BASE+0; STATUS at IO_BASE+1; CYCLES at IO_BASE+2; anything else unmapped.
- RAM: write on clk when we and RAM hit. Read returns RAM[addr] combinationally (write-first not required; same-cycle read returns old value).
- TXDATA write: push wdata into FIFO. TXDATA read returns 0.
- STATUS read: {overflow[31], 19'b0, full[11], empty[10], 5'b0, count[4:0]}. Any write to STATUS clears overflow.
- CYCLES read: 32-bit counter, +1 every cycle out of reset, wraps 32'hFFFF_FFFF -> 0. Writes ignored.
- Unmapped: reads return 32'h0, writes ignored.
- FIFO: pop when out_valid && out_ready. Push accepted when count < FIFO_DEPTH, or when full and a pop occurs the same cycle. Rejected push drops wdata and sets sticky overflow.
- Simultaneous push+pop with 0 < count: count unchanged, order preserved. Push into empty FIFO with out_ready high: no pop that cycle (head not yet valid).
- Read/write pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

## Timing

- Reset (synchronous, sampled on clk): RAM cleared to 0, FIFO pointers/count 0, overflow 0, cycle counter 0. Outputs after reset edge: out_valid 0, out_data 0 (head of cleared storage), rdata per decode of current addr.
- rdata: zero-cycle latency, purely combinational on addr and current state.
- Store-to-load: a store at edge N is visible to a load in cycle N+1.
- TXDATA push at edge N -> out_valid high in cycle N+1; out_data = pushed word.
- Pop at edge N -> next entry (or out_valid 0) in cycle N+1.
- STATUS reflects state after the previous edge; a push in the same cycle is not yet counted.
- Reset asserted mid-operation overrides any same-cycle push, pop, store, or counter increment.

## Structure

- Shared package: IO address offsets (TXDATA=0, STATUS=1, CYCLES=2), STATUS bit positions.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count, synchronous active-high reset); decode, RAM, overflow flag, and counter stay in the top.

## Test plan

- Reset, then store 13 at addr 0 and 17 at addr 31; load addr 0 -> 13, addr 31 -> 17; load addr 32 -> 0.
- Store 5, 6, 7 to TXDATA with out_ready=0 -> STATUS count=3, empty=0; raise out_ready -> out_data 5, 6, 7 on successive cycles, then out_valid 0, STATUS empty=1.
- Fill 8 entries with out_ready=0, 9th store of 32'hDEAD -> dropped, STATUS = 32'h8000_0808; write STATUS -> overflow 0; full + store with out_ready=1 same cycle -> accepted, count stays 8, order preserved.
- Read CYCLES at 10 cycles after reset release -> 10; force counter to 32'hFFFF_FFFF (hierarchical deposit) -> next cycle reads 0.
- Assert reset with FIFO holding 3 words and a concurrent store -> next cycle out_valid 0, count 0, RAM word 0, CYCLES 0.
- Random interleaved RAM stores/loads and TXDATA pushes/pops against a reference model for 2000 cycles -> no mismatches, no lost or reordered output words.
